// File: rtl/oscill_pio_pkg.sv
// ---------------------------------------------------------------------------
// oscill_pio_pkg
// Shared definitions for the oscill_nios output PIO: word addresses of the
// register map, the pulse engine state encoding and the PULSE_LEN width.
// ---------------------------------------------------------------------------
package oscill_pio_pkg;

  // Word addresses on the Avalon-MM slave (3-bit address bus).
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE  = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

  // Pulse length register width, in ticks.
  localparam int PULSE_LEN_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pulse_state_e;

endpackage : oscill_pio_pkg

// File: rtl/oscill_pio_pulse_timer.sv
// ---------------------------------------------------------------------------
// oscill_pio_pulse_timer
// Retriggerable one-shot timer behind the PIO pulse engine. A trigger latches
// the pulse length and prescale, clears the prescaler and enters RUN. In RUN
// the prescaler counts 0..prescale; each wrap is a tick that decrements the
// remaining count. The tick that sees remaining = 1 is the expiry tick.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   trigger  in   start / restart the pulse (already qualified by the top)
//   len      in   pulse length in ticks, latched on trigger
//   prescale in   clock cycles per tick minus 1, latched on trigger
//   running  out  engine is in RUN
//   expire   out  current cycle is the expiry tick (valid only in RUN)
// ---------------------------------------------------------------------------
module oscill_pio_pulse_timer
  import oscill_pio_pkg::*;
#(
  parameter int PRESCALE_W = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   trigger,
  input  logic [PULSE_LEN_W-1:0] len,
  input  logic [PRESCALE_W-1:0]  prescale,
  output logic                   running,
  output logic                   expire
);

  pulse_state_e           state_q, state_d;
  logic [PULSE_LEN_W-1:0] remaining_q, remaining_d;
  logic [PRESCALE_W-1:0]  count_q, count_d;
  logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
  logic                   tick;

  // The running pulse uses its own copy of prescale so that register writes
  // during RUN only affect the next trigger.
  assign tick = (state_q == RUN) && (count_q == prescale_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      count_q     <= '0;
      prescale_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      remaining_q <= remaining_d;
      count_q     <= count_d;
      prescale_q  <= prescale_d;
    end
  end

  // Next-state logic. A trigger always wins, including on the expiry tick.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    count_d     = count_q;
    prescale_d  = prescale_q;
    if (trigger) begin
      state_d     = RUN;
      remaining_d = len;
      count_d     = '0;
      prescale_d  = prescale;
    end else if (state_q == RUN) begin
      if (tick) begin
        count_d = '0;
        if (remaining_q == PULSE_LEN_W'(1)) begin
          state_d = IDLE;
        end else begin
          remaining_d = remaining_q - PULSE_LEN_W'(1);
        end
      end else begin
        count_d = count_q + PRESCALE_W'(1);
      end
    end
  end

  // Outputs.
  always_comb begin
    running = (state_q == RUN);
    expire  = tick && (remaining_q == PULSE_LEN_W'(1));
  end

endmodule : oscill_pio_pulse_timer

// File: rtl/oscill_nios_pio_led_out.sv
// ---------------------------------------------------------------------------
// oscill_nios_pio_led_out
// Avalon-MM output PIO for the front-panel LEDs and strobes. Holds the DATA
// register with atomic set/clear aliases and a retriggerable pulse engine;
// out_port = DATA | pulse_active, registered.
//
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   address    in   word address (see oscill_pio_pkg)
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   32-bit write data
//   readdata   out  registered read data, one cycle latency, upper bits 0
//   out_port   out  registered output pins
// ---------------------------------------------------------------------------
module oscill_nios_pio_led_out
  import oscill_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PRESCALE_W  = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]       data_q, data_d;
  logic [PULSE_LEN_W-1:0] pulse_len_q, pulse_len_d;
  logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
  logic [WIDTH-1:0]       pulse_q, pulse_d;
  logic [31:0]            readdata_q, readdata_d;
  logic [WIDTH-1:0]       out_q;

  logic             wr_en;
  logic [WIDTH-1:0] wmask;
  logic             trigger;
  logic             running;
  logic             expire;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign wmask        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Zero masks and zero lengths are dropped here so the timer never starts
  // a pulse that would have nothing to show.
  assign trigger = wr_en && (address == ADDR_PULSE) && (|wmask)
                   && (pulse_len_q != '0);

  oscill_pio_pulse_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .trigger  (trigger),
    .len      (pulse_len_q),
    .prescale (prescale_q),
    .running  (running),
    .expire   (expire)
  );

  // Register writes.
  always_comb begin
    data_d      = data_q;
    pulse_len_d = pulse_len_q;
    prescale_d  = prescale_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:      data_d      = wmask;
        ADDR_PULSE_LEN: pulse_len_d = writedata[PULSE_LEN_W-1:0];
        ADDR_PRESCALE:  prescale_d  = writedata[PRESCALE_W-1:0];
        ADDR_OUTSET:    data_d      = data_q | wmask;
        ADDR_OUTCLEAR:  data_d      = data_q & ~wmask;
        default:        ;
      endcase
    end
  end

  // Pulse bits. A retrigger on the expiry tick replaces the expiring set
  // with the new mask; otherwise a retrigger merges so all bits end together.
  always_comb begin
    pulse_d = pulse_q;
    if (trigger) begin
      pulse_d = expire ? wmask : (pulse_q | wmask);
    end else if (expire || !running) begin
      pulse_d = '0;
    end
  end

  // Read mux, registered every cycle regardless of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLEAR: readdata_d[WIDTH-1:0]       = data_q;
      ADDR_PULSE_LEN:                        readdata_d[PULSE_LEN_W-1:0] = pulse_len_q;
      ADDR_PRESCALE:                         readdata_d[PRESCALE_W-1:0]  = prescale_q;
      ADDR_PULSE:                            readdata_d[WIDTH-1:0]       = pulse_q;
      default:                               ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q      <= RESET_VALUE;
      pulse_len_q <= '0;
      prescale_q  <= '0;
      pulse_q     <= '0;
      readdata_q  <= '0;
      out_q       <= RESET_VALUE;
    end else begin
      data_q      <= data_d;
      pulse_len_q <= pulse_len_d;
      prescale_q  <= prescale_d;
      pulse_q     <= pulse_d;
      readdata_q  <= readdata_d;
      out_q       <= data_q | pulse_q;
    end
  end

  assign readdata = readdata_q;
  assign out_port = out_q;

endmodule : oscill_nios_pio_led_out

// File: tb/tb_oscill_nios_pio_led_out.sv
// ---------------------------------------------------------------------------
// Testbench for oscill_nios_pio_led_out (WIDTH=8, RESET_VALUE=8'hA5).
// A cycle-level reference model tracks registers and the pulse as an absolute
// end time; table vectors and hand sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_oscill_nios_pio_led_out;

  localparam logic [7:0] RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  oscill_nios_pio_led_out #(
    .WIDTH       (8),
    .RESET_VALUE (RV),
    .PRESCALE_W  (24)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pulse described by its bit set and the edge it ends on.
  longint      cyc = 0;
  logic [7:0]  m_data;
  int          m_len, m_presc;
  logic [7:0]  m_pulse;
  bit          m_active;
  longint      m_end;
  logic [7:0]  exp_out;
  logic [31:0] exp_rd;

  task automatic model_edge(input logic rst, input logic cs, input logic wn,
                            input logic [2:0] a, input logic [31:0] d);
    cyc++;
    if (!rst) begin
      m_data = RV; m_len = 0; m_presc = 0; m_pulse = '0; m_active = 0;
      exp_out = RV; exp_rd = '0;
      return;
    end
    exp_out = m_data | m_pulse;
    case (a)
      3'd0, 3'd4, 3'd5: exp_rd = 32'(m_data);
      3'd1:             exp_rd = 32'(m_len);
      3'd2:             exp_rd = 32'(m_presc);
      3'd3:             exp_rd = 32'(m_pulse);
      default:          exp_rd = '0;
    endcase
    if (m_active && cyc == m_end) begin
      m_pulse = '0;
      m_active = 0;
    end
    if (cs && !wn) begin
      case (a)
        3'd0: m_data = d[7:0];
        3'd1: m_len = int'(d[15:0]);
        3'd2: m_presc = int'(d[23:0]);
        3'd3: if (d[7:0] != 0 && m_len != 0) begin
                m_pulse  = m_pulse | d[7:0];
                m_active = 1;
                m_end    = cyc + longint'(m_len) * longint'(m_presc + 1);
              end
        3'd4: m_data = m_data | d[7:0];
        3'd5: m_data = m_data & ~d[7:0];
        default: ;
      endcase
    end
  endtask

  // Trace of outputs after each edge, indexed from the last clear of tr_n.
  logic [7:0]  tr  [0:63];
  logic [31:0] rtr [0:63];
  int          tr_n = 0;

  task automatic step(input logic rst, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] d);
    reset_n = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
    @(posedge clk);
    model_edge(rst, cs, wn, a, d);
    #1;
    check("out_port", 32'(out_port), 32'(exp_out));
    check("readdata", readdata, exp_rd);
    if (tr_n < 64) begin
      tr[tr_n]  = out_port;
      rtr[tr_n] = readdata;
      tr_n++;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b1, a, 32'h0);
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [0:31];
  int   n_tbl = 0;

  task automatic add_vec(input logic cs, input logic wn, input logic [2:0] a,
                         input logic [31:0] wd, input logic [7:0] eo, input logic [31:0] er);
    tbl[n_tbl].cs = cs; tbl[n_tbl].wn = wn; tbl[n_tbl].addr = a;
    tbl[n_tbl].wd = wd; tbl[n_tbl].exp_out = eo; tbl[n_tbl].exp_rd = er;
    n_tbl++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          hi;
    int          bad;
    int unsigned r;
    logic [2:0]  ra;
    logic [31:0] rw;
    logic        rc, rn, rr;

    // Register map after reset, then DATA/OUTSET/OUTCLEAR and ignored writes.
    add_vec(1, 1, 3'd0, 0, RV, 32'hA5);
    add_vec(1, 1, 3'd1, 0, RV, 32'h0);
    add_vec(1, 1, 3'd2, 0, RV, 32'h0);
    add_vec(1, 1, 3'd3, 0, RV, 32'h0);
    add_vec(1, 1, 3'd4, 0, RV, 32'hA5);
    add_vec(1, 1, 3'd5, 0, RV, 32'hA5);
    add_vec(1, 1, 3'd6, 0, RV, 32'h0);
    add_vec(1, 1, 3'd7, 0, RV, 32'h0);
    add_vec(1, 0, 3'd0, 32'h0000_000F, RV,    32'hA5);
    add_vec(1, 0, 3'd4, 32'h0000_0030, 8'h0F, 32'h0F);
    add_vec(1, 0, 3'd5, 32'h0000_0003, 8'h3F, 32'h3F);
    add_vec(1, 1, 3'd0, 0,             8'h3C, 32'h3C);
    add_vec(1, 0, 3'd6, 32'hFFFF_FFFF, 8'h3C, 32'h0);
    add_vec(1, 0, 3'd7, 32'hFFFF_FFFF, 8'h3C, 32'h0);
    add_vec(0, 0, 3'd0, 32'h0000_00FF, 8'h3C, 32'h3C);
    add_vec(0, 0, 3'd1, 32'h0000_1234, 8'h3C, 32'h0);
    add_vec(1, 1, 3'd1, 0,             8'h3C, 32'h0);
    add_vec(1, 1, 3'd0, 0,             8'h3C, 32'h3C);

    step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    check("reset_out", 32'(out_port), 32'hA5);
    check("reset_rd", readdata, 32'h0);

    for (int i = 0; i < n_tbl; i++) begin
      step(1'b1, tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd);
      check($sformatf("tbl%0d_out", i), 32'(out_port), 32'(tbl[i].exp_out));
      check($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
    end

    // Single pulse: 5 ticks of 4 cycles on bit 7.
    wr(3'd0, 32'h0);
    wr(3'd2, 32'd3);
    wr(3'd1, 32'd5);
    tr_n = 0;
    wr(3'd3, 32'h80);
    rd(3'd3, 29);
    hi = 0;
    for (int k = 0; k < 30; k++) if (tr[k][7]) hi++;
    check("pulse_width", 32'(hi), 32'd20);
    check("pulse_first", 32'(tr[1]), 32'h80);
    check("pulse_last", 32'(tr[20]), 32'h80);
    check("pulse_after", 32'(tr[21]), 32'h00);
    check("pulse_rd_during", rtr[10], 32'h80);
    check("pulse_rd_after", rtr[21], 32'h0);

    // Retrigger mid-pulse: both bits end together.
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd10);
    tr_n = 0;
    wr(3'd3, 32'h01);
    rd(3'd3, 5);
    wr(3'd3, 32'h02);
    rd(3'd3, 14);
    check("retrig_b0_only", 32'(tr[6]), 32'h01);
    check("retrig_merged", 32'(tr[7]), 32'h03);
    check("retrig_last", 32'(tr[16]), 32'h03);
    check("retrig_fall", 32'(tr[17]), 32'h00);

    // Retrigger on the expiry tick: only the new mask survives.
    wr(3'd1, 32'd3);
    tr_n = 0;
    wr(3'd3, 32'h01);
    rd(3'd3, 2);
    wr(3'd3, 32'h04);
    rd(3'd3, 5);
    check("exp_retrig_old", 32'(tr[3]), 32'h01);
    check("exp_retrig_new", 32'(tr[4]), 32'h04);
    check("exp_retrig_hold", 32'(tr[6]), 32'h04);
    check("exp_retrig_end", 32'(tr[7]), 32'h00);

    // PULSE_LEN = 0 and zero mask are ignored.
    wr(3'd1, 32'd0);
    tr_n = 0;
    wr(3'd3, 32'hFF);
    rd(3'd3, 4);
    check("len0_out", 32'(tr[2]), 32'h00);
    check("len0_rd", rtr[3], 32'h0);
    wr(3'd1, 32'd4);
    tr_n = 0;
    wr(3'd3, 32'hFFFF_FF00);
    rd(3'd3, 4);
    check("mask0_out", 32'(tr[2]), 32'h00);
    check("mask0_rd", rtr[3], 32'h0);

    // Reset mid-pulse aborts the pulse.
    wr(3'd1, 32'd20);
    wr(3'd3, 32'h10);
    rd(3'd3, 3);
    step(1'b0, 1'b1, 1'b1, 3'd3, 32'h0);
    check("midrst_out", 32'(out_port), 32'hA5);
    tr_n = 0;
    rd(3'd3, 25);
    bad = 0;
    for (int k = 0; k < 25; k++) if (tr[k] != RV) bad++;
    check("midrst_no_pulse", 32'(bad), 32'd0);
    check("midrst_rd", rtr[24], 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom;
      ra = 3'($urandom_range(0, 7));
      rc = ($urandom_range(0, 7) != 0);
      rn = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 255) != 0);
      case (ra)
        3'd1:    rw = {r[31:16], 16'($urandom_range(0, 8))};
        3'd2:    rw = {r[31:24], 24'($urandom_range(0, 3))};
        3'd3: begin
          rw = r;
          if ($urandom_range(0, 5) == 0) rw[7:0] = 8'h00;
        end
        default: rw = r;
      endcase
      step(rr, rc, rn, ra, rw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_oscill_nios_pio_led_out
